// File: rtl/zrc_out_pack.sv
// Packs the ZRC mapped 8-bit pixel stream into 32-bit words and buffers them in a show-ahead
// FIFO for the video DMA. Define ZRC_PACK_FIFO_LEVEL_EN to expose FIFO level/high-water ports.
module zrc_out_pack #(
  parameter int unsigned IMAGE_WIDTH = 640,
  parameter int unsigned FIFO_AW     = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_field_vld,
  input  logic              i_line_vld,
  input  logic [7:0]        i_img_data,
  input  logic              i_err_clr,
  output logic [31:0]       o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tuser,
  output logic              o_tlast,
  output logic              o_overflow,
  output logic              o_line_err,
  output logic [15:0]       o_frame_cnt
`ifdef ZRC_PACK_FIFO_LEVEL_EN
  ,
  output logic [FIFO_AW:0]  o_fifo_level,
  output logic [FIFO_AW:0]  o_level_max
`endif
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned PW    = $clog2(IMAGE_WIDTH + 1);
  localparam logic [PW-1:0]      Width   = PW'(IMAGE_WIDTH);
  localparam logic [PW-1:0]      LastPix = PW'(IMAGE_WIDTH - 1);
  localparam logic [FIFO_AW:0]   Full    = (FIFO_AW + 1)'(Depth);

  logic            field_q, line_q;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     acc_q, acc_d;
  logic            stg_vld_q, stg_vld_d;
  logic [31:0]     stg_word_q, stg_word_d;
  logic            stg_last_q, stg_last_d;
  logic            sof_q, sof_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;
  logic [15:0]     fcnt_q, fcnt_d;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [33:0]     mem [Depth];

  logic line_rise, line_fall, field_rise, field_fall, pix, lerr_set;
  logic [PW-1:0] cnt;
  logic [1:0]    lane;
  logic [31:0]   acc, merged;
  logic [FIFO_AW:0] level;
  logic empty, full, pop, push, ovf_set;
  logic [33:0] head;

  assign line_rise  = i_line_vld & ~line_q;
  assign line_fall  = ~i_line_vld & line_q;
  assign field_rise = i_field_vld & ~field_q;
  assign field_fall = ~i_field_vld & field_q;
  assign pix        = i_field_vld & i_line_vld;

  // The rising-edge cycle already carries the first pixel of the line.
  assign cnt  = line_rise ? '0 : pcnt_q;
  assign lane = line_rise ? 2'd0 : lane_q;
  assign acc  = line_rise ? '0 : acc_q;

  always_comb begin
    merged = acc;
    merged[{lane, 3'b000} +: 8] = i_img_data;
    pcnt_d     = cnt;
    lane_d     = lane;
    acc_d      = acc;
    stg_vld_d  = 1'b0;
    stg_word_d = stg_word_q;
    stg_last_d = 1'b0;
    lerr_set   = 1'b0;
    if (pix) begin
      if (cnt < Width) begin
        pcnt_d = cnt + PW'(1);
        if (lane == 2'd3 || cnt == LastPix) begin
          stg_vld_d  = 1'b1;
          stg_word_d = merged;
          stg_last_d = (cnt == LastPix);
          acc_d      = '0;
          lane_d     = 2'd0;
        end else begin
          acc_d  = merged;
          lane_d = lane + 2'd1;
        end
      end else begin
        lerr_set = 1'b1;
      end
    end else if (line_fall && pcnt_q < Width) begin
      lerr_set = 1'b1;
      // Flush the partial word; unused bytes of acc are already zero.
      if (lane_q != 2'd0) begin
        stg_vld_d  = 1'b1;
        stg_word_d = acc_q;
        stg_last_d = 1'b1;
        acc_d      = '0;
        lane_d     = 2'd0;
      end
    end
  end

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == Full);
  assign pop     = ~empty & i_tready;
  assign push    = stg_vld_q & (~full | pop);
  assign ovf_set = stg_vld_q & full & ~pop;

  always_comb begin
    sof_d  = field_rise | (sof_q & ~stg_vld_q);
    ovf_d  = ovf_set | (ovf_q & ~i_err_clr);
    lerr_d = lerr_set | (lerr_q & ~i_err_clr);
    fcnt_d = fcnt_q + 16'(field_fall);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      field_q    <= 1'b0;
      line_q     <= 1'b0;
      pcnt_q     <= '0;
      lane_q     <= 2'd0;
      acc_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_word_q <= '0;
      stg_last_q <= 1'b0;
      sof_q      <= 1'b0;
      ovf_q      <= 1'b0;
      lerr_q     <= 1'b0;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      field_q    <= i_field_vld;
      line_q     <= i_line_vld;
      pcnt_q     <= pcnt_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      stg_vld_q  <= stg_vld_d;
      stg_word_q <= stg_word_d;
      stg_last_q <= stg_last_d;
      sof_q      <= sof_d;
      ovf_q      <= ovf_d;
      lerr_q     <= lerr_d;
      fcnt_q     <= fcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= {sof_q, stg_last_q, stg_word_q};
  end

  assign head        = mem[rd_ptr_q[FIFO_AW-1:0]];
  assign o_tvalid    = ~empty;
  assign o_tdata     = empty ? 32'd0 : head[31:0];
  assign o_tlast     = ~empty & head[32];
  assign o_tuser     = ~empty & head[33];
  assign o_overflow  = ovf_q;
  assign o_line_err  = lerr_q;
  assign o_frame_cnt = fcnt_q;

`ifdef ZRC_PACK_FIFO_LEVEL_EN
  logic [FIFO_AW:0] lmax_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_err_clr) lmax_q <= '0;
    else if (level > lmax_q) lmax_q <= level;
  end

  assign o_fifo_level = level;
  assign o_level_max  = lmax_q;
`endif

endmodule

// File: tb/tb_zrc_out_pack.sv
// Directed bench for zrc_out_pack: packing, SOF/EOL, short lines, overflow, reset, flag clear.
module tb_zrc_out_pack;
  localparam int unsigned IW = 640;
  localparam int unsigned AW = 2;

  logic        clk = 1'b0;
  logic        rst, field_vld, line_vld, err_clr, tready;
  logic [7:0]  img_data;
  logic [31:0] tdata;
  logic        tvalid, tuser, tlast, overflow, line_err;
  logic [15:0] frame_cnt;
`ifdef ZRC_PACK_FIFO_LEVEL_EN
  logic [AW:0] fifo_level, level_max;
`endif

  zrc_out_pack #(.IMAGE_WIDTH(IW), .FIFO_AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_field_vld(field_vld), .i_line_vld(line_vld),
    .i_img_data(img_data), .i_err_clr(err_clr), .o_tdata(tdata), .o_tvalid(tvalid),
    .i_tready(tready), .o_tuser(tuser), .o_tlast(tlast), .o_overflow(overflow),
    .o_line_err(line_err), .o_frame_cnt(frame_cnt)
`ifdef ZRC_PACK_FIFO_LEVEL_EN
    , .o_fifo_level(fifo_level), .o_level_max(level_max)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q_data[$];
  logic        q_user[$];
  logic        q_last[$];

  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      q_data.push_back(tdata);
      q_user.push_back(tuser);
      q_last.push_back(tlast);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_q();
    q_data.delete();
    q_user.delete();
    q_last.delete();
  endtask

  // Leaves line_vld low after the last pixel without advancing the clock.
  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      line_vld = 1'b1;
      img_data = 8'(base + i);
      tick();
    end
    line_vld = 1'b0;
    img_data = 8'd0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) tick();
  endtask

  function automatic logic [31:0] word_at(input int p);
    return {8'(p + 3), 8'(p + 2), 8'(p + 1), 8'(p)};
  endfunction

  initial begin
    int bad;
    rst = 1'b1; field_vld = 1'b0; line_vld = 1'b0; img_data = 8'd0;
    err_clr = 1'b0; tready = 1'b1;
    idle(3);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_flags", {28'd0, tuser, tlast, overflow, line_err}, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Two full lines, sink always ready.
    field_vld = 1'b1; tick();
    send_line(IW, 0); idle(3);
    send_line(IW, 0); idle(3);
    field_vld = 1'b0; tick();
    wait_words(320, 60);
    check("t1_words", q_data.size(), 32'd320);
    if (q_data.size() == 320) begin
      bad = 0;
      for (int k = 0; k < 320; k++) begin
        if (q_data[k] !== word_at(4 * (k % 160))) bad++;
        if (q_user[k] !== (k == 0)) bad++;
        if (q_last[k] !== (k % 160 == 159)) bad++;
      end
      check("t1_word_errs", bad, 32'd0);
      check("t1_word0", q_data[0], 32'h03020100);
      check("t1_tuser0", 32'(q_user[0]), 32'd1);
      check("t1_tlast159", 32'(q_last[159]), 32'd1);
      check("t1_tlast319", 32'(q_last[319]), 32'd1);
      check("t1_tlast158", 32'(q_last[158]), 32'd0);
    end
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_line_err", 32'(line_err), 32'd0);
    clr_q();

    // Short 6-pixel line: partial flush with zero fill.
    field_vld = 1'b1; tick();
    send_line(6, 8'h10); idle(4);
    field_vld = 1'b0; tick();
    wait_words(2, 20);
    check("t2_words", q_data.size(), 32'd2);
    if (q_data.size() == 2) begin
      check("t2_w0", q_data[0], 32'h13121110);
      check("t2_w1", q_data[1], 32'h00001514);
      check("t2_last", {30'd0, q_last[0], q_last[1]}, 32'd1);
      check("t2_tuser0", 32'(q_user[0]), 32'd1);
    end
    check("t2_line_err", 32'(line_err), 32'd1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t2_err_clr", 32'(line_err), 32'd0);
    clr_q();

    // Stalled sink, 24 pixels into a 4-deep FIFO.
    tready = 1'b0;
    field_vld = 1'b1; tick();
    send_line(24, 8'h40); idle(4);
    check("t3_tvalid", 32'(tvalid), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_head", tdata, 32'h43424140);
    check("t3_tuser", 32'(tuser), 32'd1);
    idle(5);
    check("t3_head_hold", tdata, 32'h43424140);
`ifdef ZRC_PACK_FIFO_LEVEL_EN
    check("t3_level", 32'(fifo_level), 32'd4);
`endif
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t6_clr_alone", 32'(overflow), 32'd0);
    // err_clr lands in the same cycle as the dropped write.
    send_line(4, 8'h60);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t6_clr_race", 32'(overflow), 32'd1);
    tready = 1'b1;
    wait_words(4, 20); idle(5);
    check("t3_drained", q_data.size(), 32'd4);
    if (q_data.size() == 4) begin
      check("t3_d0", q_data[0], 32'h43424140);
      check("t3_d3", q_data[3], 32'h4f4e4d4c);
    end
    check("t3_empty", 32'(tvalid), 32'd0);
    clr_q();

    // Full FIFO with push and pop in the same cycle.
    tready = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send_line(16, 8'h80); idle(3);
    check("t4_full_valid", 32'(tvalid), 32'd1);
    send_line(4, 8'hA0);
    tready = 1'b1; tick(); tready = 1'b0;
    idle(2);
    check("t4_no_overflow", 32'(overflow), 32'd0);
    check("t4_one_pop", q_data.size(), 32'd1);
`ifdef ZRC_PACK_FIFO_LEVEL_EN
    check("t4_level", 32'(fifo_level), 32'd4);
`endif
    tready = 1'b1;
    wait_words(5, 20); idle(3);
    check("t4_words", q_data.size(), 32'd5);
    if (q_data.size() == 5) begin
      check("t4_w0", q_data[0], 32'h83828180);
      check("t4_w4", q_data[4], 32'ha3a2a1a0);
    end
`ifdef ZRC_PACK_FIFO_LEVEL_EN
    check("t4_level_max", 32'(level_max), 32'd4);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t6_level_max_clr", 32'(level_max), 32'd0);
`endif
    clr_q();

    // Reset mid-line with words buffered, then a clean line.
    tready = 1'b0;
    field_vld = 1'b0; tick();
    field_vld = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      line_vld = 1'b1; img_data = 8'(8'hC0 + i); tick();
    end
    check("t5_pre_valid", 32'(tvalid), 32'd1);
    rst = 1'b1; line_vld = 1'b0; field_vld = 1'b0; tick();
    rst = 1'b0;
    check("t5_tvalid", 32'(tvalid), 32'd0);
    check("t5_tdata", tdata, 32'd0);
    check("t5_flags", {30'd0, overflow, line_err}, 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    tready = 1'b1;
    field_vld = 1'b1; tick();
    send_line(IW, 8'h07); idle(3);
    field_vld = 1'b0; tick();
    wait_words(160, 40);
    check("t5_words", q_data.size(), 32'd160);
    if (q_data.size() == 160) begin
      check("t5_w0", q_data[0], 32'h0a090807);
      check("t5_tuser0", 32'(q_user[0]), 32'd1);
      check("t5_tlast", 32'(q_last[159]), 32'd1);
    end
    check("t5_line_err", 32'(line_err), 32'd0);
    check("t5_frame_cnt1", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
